// File: rtl/signed_fxp_pkg.sv
// Shared constants, types and helpers for the signed fixed-point multiplier.
// Build option SIGNED_FXP_MUL_ROUND_EN selects round-half-away-from-zero in S3.
package signed_fxp_pkg;

    localparam int unsigned DEF_W    = 32'd16;
    localparam int unsigned DEF_FRAC = 32'd12;

    // Stage payload at the default width: result sign plus operand magnitudes.
    typedef struct packed {
        logic              sign;
        logic [DEF_W-1:0]  mag_a;
        logic [DEF_W-1:0]  mag_b;
    } fxp_payload_t;

    // Largest positive two's-complement code of a w-bit word: 2^(w-1)-1.
    function automatic logic [31:0] max_pos_code(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    // Real value to nearest Q-format integer code with frac fractional bits.
    function automatic int to_q(input real x, input int unsigned frac);
        real scaled;
        scaled = x * (2.0 ** frac);
        if (scaled >= 0.0) begin
            return $rtoi(scaled + 0.5);
        end else begin
            return -$rtoi(-scaled + 0.5);
        end
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational output stage: rescale the magnitude product, optionally round,
// clamp to the symmetric range, flag clamping and apply the sign.
// Build option SIGNED_FXP_MUL_ROUND_EN adds half an LSB before the shift.
module fxp_round_sat
    import signed_fxp_pkg::*;
#(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned FRAC = DEF_FRAC
) (
    input  logic           sign,
    input  logic [2*W-1:0] prod,
    output logic [W-1:0]   c,
    output logic           sat
);

    localparam logic [W-1:0] MAX_POS = W'(max_pos_code(W));
`ifdef SIGNED_FXP_MUL_ROUND_EN
    // Largest magnitude product is 2^(2W-2), so adding half an LSB cannot overflow 2W bits.
    localparam logic [2*W-1:0] HALF_LSB = {{(2*W-1){1'b0}}, 1'b1} << (FRAC - 32'd1);
`endif

    logic [2*W-1:0] biased_s;
    logic [2*W-1:0] shifted_s;
    logic [W-1:0]   mag_s;

    // Rescale, clamp to +/-(2^(W-1)-1) and negate; zero stays zero for either sign.
    always_comb begin
`ifdef SIGNED_FXP_MUL_ROUND_EN
        biased_s = prod + HALF_LSB;
`else
        biased_s = prod;
`endif
        shifted_s = biased_s >> FRAC;
        if (shifted_s > {{W{1'b0}}, MAX_POS}) begin
            sat   = 1'b1;
            mag_s = MAX_POS;
        end else begin
            sat   = 1'b0;
            mag_s = shifted_s[W-1:0];
        end
        if (sign) begin
            c = ~mag_s + {{(W-1){1'b0}}, 1'b1};
        end else begin
            c = mag_s;
        end
    end

endmodule

// File: rtl/signed_fxp_mul_pipe.sv
// Three-stage pipelined signed fixed-point multiplier with valid/ready flow
// control, symmetric saturation, per-result clamp flag and a clamp counter.
// Build option SIGNED_FXP_MUL_ROUND_EN enables rounding in the output stage.
module signed_fxp_mul_pipe
    import signed_fxp_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned FRAC  = DEF_FRAC,
    parameter int unsigned CNT_W = 32'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     c,
    output logic             c_sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_cnt_clr
);

    typedef struct packed {
        logic          sign;
        logic [W-1:0]  mag_a;
        logic [W-1:0]  mag_b;
    } s1_payload_t;

    typedef struct packed {
        logic           sign;
        logic [2*W-1:0] prod;
    } s2_payload_t;

    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    logic             adv_s;
    logic             xfer_out_s;
    s1_payload_t      s1_next_s;
    s2_payload_t      s2_next_s;
    s1_payload_t      s1_r;
    s2_payload_t      s2_r;
    logic             v1_r;
    logic             v2_r;
    logic             out_valid_r;
    logic [W-1:0]     c_next_s;
    logic             sat_next_s;
    logic [W-1:0]     c_r;
    logic             c_sat_r;
    logic [CNT_W-1:0] sat_cnt_r;

    // Global advance and stage-1/2 datapath: magnitudes, result sign, full product.
    always_comb begin
        adv_s      = !out_valid_r || out_ready;
        xfer_out_s = out_valid_r && out_ready;
        s1_next_s.sign = a[W-1] ^ b[W-1];
        if (a[W-1]) begin
            s1_next_s.mag_a = ~a + ONE_W;
        end else begin
            s1_next_s.mag_a = a;
        end
        if (b[W-1]) begin
            s1_next_s.mag_b = ~b + ONE_W;
        end else begin
            s1_next_s.mag_b = b;
        end
        s2_next_s.sign = s1_r.sign;
        s2_next_s.prod = {{W{1'b0}}, s1_r.mag_a} * {{W{1'b0}}, s1_r.mag_b};
    end

    fxp_round_sat #(
        .W    (W),
        .FRAC (FRAC)
    ) u_round_sat (
        .sign (s2_r.sign),
        .prod (s2_r.prod),
        .c    (c_next_s),
        .sat  (sat_next_s)
    );

    // Pipeline registers: every stage moves together on advance, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            out_valid_r <= 1'b0;
            s1_r        <= {$bits(s1_payload_t){1'b0}};
            s2_r        <= {$bits(s2_payload_t){1'b0}};
            c_r         <= {W{1'b0}};
            c_sat_r     <= 1'b0;
        end else if (adv_s) begin
            v1_r        <= in_valid;
            v2_r        <= v1_r;
            out_valid_r <= v2_r;
            if (in_valid) begin
                s1_r <= s1_next_s;
            end
            if (v1_r) begin
                s2_r <= s2_next_s;
            end
            if (v2_r) begin
                c_r     <= c_next_s;
                c_sat_r <= sat_next_s;
            end
        end
    end

    // Clamp-event counter: clear has priority, then count saturated transfers without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if (sat_cnt_clr) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if (xfer_out_s && c_sat_r && !(&sat_cnt_r)) begin
            sat_cnt_r <= sat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign c_sat     = c_sat_r;
    assign sat_cnt   = sat_cnt_r;

endmodule

// File: tb/tb_signed_fxp_mul_pipe.sv
// Scoreboard bench for signed_fxp_mul_pipe at W=16, FRAC=12.
// Honours SIGNED_FXP_MUL_ROUND_EN for the rounding-sensitive vectors.
module tb_signed_fxp_mul_pipe;
    import signed_fxp_pkg::*;

    localparam int W     = 16;
    localparam int FRAC  = 12;
    localparam int CNT_W = 16;
`ifdef SIGNED_FXP_MUL_ROUND_EN
    localparam logic [15:0] HALF_POS = 16'h0001;
    localparam logic [15:0] HALF_NEG = 16'hFFFF;
`else
    localparam logic [15:0] HALF_POS = 16'h0000;
    localparam logic [15:0] HALF_NEG = 16'h0000;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a = 16'h0000;
    logic [W-1:0]     b = 16'h0000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     c;
    logic             c_sat;
    logic [CNT_W-1:0] sat_cnt;
    logic             sat_cnt_clr = 1'b0;

    typedef struct {
        logic [15:0] c;
        logic        sat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic        acc = 1'b0;

    signed_fxp_mul_pipe #(.W(W), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .c_sat       (c_sat),
        .sat_cnt     (sat_cnt),
        .sat_cnt_clr (sat_cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference product from full-precision integer arithmetic.
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] rc, output logic rs);
        longint p;
        longint mg;
        p  = longint'($signed(x)) * longint'($signed(y));
        mg = (p < 0) ? -p : p;
`ifdef SIGNED_FXP_MUL_ROUND_EN
        mg = mg + 64'sd2048;
`endif
        mg = mg >>> 12;
        rs = (mg > 64'sd32767);
        if (rs) mg = 64'sd32767;
        rc = (p < 0) ? 16'(-mg) : 16'(mg);
    endfunction

    // One cycle: drive at negedge, score what the next posedge will transfer.
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] ec, input logic es,
                        input logic ordy, input logic clr);
        exp_t e;
        logic xo;
        logic popped_sat;
        @(negedge clk);
        in_valid    = iv;
        a           = ia;
        b           = ib;
        out_ready   = ordy;
        sat_cnt_clr = clr;
        #1;
        check("sat_cnt", 32'(sat_cnt), 32'(exp_cnt));
        popped_sat = 1'b0;
        xo = out_valid && out_ready;
        if (out_valid && !out_ready && exp_q.size() > 0) begin
            check("c_hold", 32'(c), 32'(exp_q[0].c));
            check("c_sat_hold", 32'(c_sat), 32'(exp_q[0].sat));
        end
        if (xo) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                popped_sat = e.sat;
                check("c", 32'(c), 32'(e.c));
                check("c_sat", 32'(c_sat), 32'(e.sat));
            end
        end
        if (clr) begin
            exp_cnt = 16'h0000;
        end else if (popped_sat && exp_cnt != 16'hFFFF) begin
            exp_cnt = exp_cnt + 16'd1;
        end
        acc = iv && in_ready;
        if (acc) begin
            e.c   = ec;
            e.sat = es;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_model(input logic [15:0] ia, input logic [15:0] ib, input logic ordy);
        logic [15:0] ec;
        logic        es;
        model(ia, ib, ec, es);
        step(1'b1, ia, ib, ec, es, ordy, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [15:0] dir_a [6] = '{16'h1000, 16'hE800, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
    logic [15:0] dir_b [6] = '{16'h2000, 16'h2000, 16'h1000, 16'h7FFF, 16'h0800, 16'h0800};
    logic [15:0] dir_c [6] = '{16'h2000, 16'hD000, 16'h8001, 16'h7FFF, HALF_POS, HALF_NEG};
    logic        dir_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic [15:0] one_q;
        logic [15:0] two_q;
        int          lat;
        int          sent;
        int          k;
        logic        ordy;
        logic [15:0] ec;
        logic        es;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_c_sat", 32'(c_sat), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);

        // Latency: 1.0 x 2.0
        one_q = 16'(to_q(1.0, FRAC));
        two_q = 16'(to_q(2.0, FRAC));
        step(1'b1, one_q, two_q, 16'h2000, 1'b0, 1'b1, 1'b0);
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            idle();
            if (out_valid && lat == 0) lat = n;
        end
        check("latency", 32'(lat), 32'd3);
        drain();

        // Directed vectors back to back
        for (int i = 0; i < 6; i++) step(1'b1, dir_a[i], dir_b[i], dir_c[i], dir_s[i], 1'b1, 1'b0);
        drain();
        idle();
        check("sat_cnt_after_dir", 32'(sat_cnt), 32'd2);

        // Eight-pair stream with a five-cycle output stall
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        sent = 0;
        k = 0;
        while (sent < 8 && k < 40) begin
            ordy = !(k >= 5 && k < 10);
            model(sa[sent], sb[sent], ec, es);
            step(1'b1, sa[sent], sb[sent], ec, es, ordy, 1'b0);
            if (!ordy) check("in_ready_stall", 32'(in_ready), 32'd0);
            if (acc) sent++;
            k++;
        end
        check("stream_sent", 32'(sent), 32'd8);
        drain();

        // Clear coinciding with a saturated output transfer
        send_model(16'h7FFF, 16'h7FFF, 1'b1);
        idle();
        idle();
        step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        idle();
        check("clr_wins", 32'(sat_cnt), 32'd0);

        // Drive the counter to all-ones and keep saturating
        for (int i = 0; i < 65540; i++) step(1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        drain();
        idle();
        check("sat_cnt_hold", 32'(sat_cnt), 32'h0000FFFF);

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) send_model(16'h1000, 16'h1000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_c", 32'(c), 32'd0);
        check("midrst_c_sat", 32'(c_sat), 32'd0);
        exp_q.delete();
        exp_cnt = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle();
            check("no_spurious", 32'(out_valid), 32'd0);
        end
        send_model(16'hC000, 16'h1800, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_fxp_mul_pipe.md
Name: signed_fxp_mul_pipe

Overview:
Parametrised, pipelined signed fixed-point multiplier for the attention datapath; successor to the fixed 16-bit Q3.12 multiplier.
- Generalised in width and fraction bits.
- Adds valid/ready flow control with backpressure, symmetric saturation and a per-result saturation flag.
- Adds a saturation-event counter.
- Sits between the score/weight operand buffers and the accumulator stage.

Parameters:
W, 16, operand and result width (two's complement), 4..32
FRAC, 12, fractional bits of operands and result, 1..W-1
CNT_W, 16, width of the saturation-event counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  W  signed operand, Q(W-1-FRAC).FRAC
b  in  W  signed operand, same format
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
c  out  W  signed product, same format as operands
c_sat  out  1  result was clamped
sat_cnt  out  CNT_W  number of clamped results since reset/clear
sat_cnt_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset (async assert, sync-to-clk release): all stage valids 0, out_valid=0, c=0, c_sat=0, sat_cnt=0. Reset mid-operation discards all in-flight data; no output after release until new input.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages move together only when adv=1; when adv=0 every stage holds data and valid.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- S1 (register): |a|, |b| as W-bit unsigned magnitudes; sign = a[W-1]^b[W-1]. Magnitude of -2^(W-1) is 2^(W-1) and fits unsigned W.
- S2 (register): unsigned 2W-bit product of the magnitudes.
- S3 (register):
  - m = product >> FRAC, truncation toward zero.
  - Clamp: if m > 2^(W-1)-1, set m = 2^(W-1)-1 and c_sat=1.
  - c = sign ? -m : m. Result range is symmetric: -(2^(W-1)-1) .. 2^(W-1)-1; code 0x8000 is never produced (W=16).
  - A zero product gives c=0 regardless of sign.
- Latency: 3 cycles from input transfer to out_valid with no backpressure. Throughput 1/cycle. Bubbles (in_valid=0) propagate as invalid slots and are not compressed.
- sat_cnt:
  - Increments by 1 on each output transfer with c_sat=1.
  - Saturates at all-ones (no wrap).
  - sat_cnt_clr forces 0; if a clear coincides with an increment, the clear wins.
- c and c_sat are stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro SIGNED_FXP_MUL_ROUND_EN.
- Defined: S3 computes m = (product + 2^(FRAC-1)) >> FRAC, i.e. round half away from zero (applied to the magnitude). Clamping and the flag are evaluated after rounding.
- Undefined: truncation toward zero as above.
- Latency and ports are identical in both builds.

Decomposition:
- Package signed_fxp_pkg:
  - Default W and FRAC constants.
  - Function for the max positive code, 2^(W-1)-1.
  - Function for Q-format conversion used by benches.
  - Typedef for the stage payload {sign, magnitude}.
- One sub-module fxp_round_sat: combinational shift, optional round, clamp, negate, sat flag. The pipeline/handshake wrapper instantiates it in S3.

Test Plan (W=16, FRAC=12):
- 0x1000 (1.0) x 0x2000 (2.0), out_ready=1 -> c=0x2000, c_sat=0, out_valid exactly 3 cycles after accept.
- 0xE800 (-1.5) x 0x2000 -> c=0xD000 (-3.0); 0x8000 x 0x1000 -> c=0x8001, c_sat=1; 0x7FFF x 0x7FFF -> c=0x7FFF, c_sat=1, sat_cnt=2.
- 0x0001 x 0x0800 and 0xFFFF x 0x0800 -> c=0x0000 both (truncate); with SIGNED_FXP_MUL_ROUND_EN -> 0x0001 and 0xFFFF.
- Stream 8 back-to-back pairs, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, c held stable, all 8 results in order, none lost or duplicated.
- sat_cnt_clr=1 in the same cycle as a saturated output transfer -> sat_cnt=0 next cycle; force counter to 0xFFFF and saturate again -> stays 0xFFFF.
- Assert rst_n low with 3 results in flight -> out_valid=0 and c=0 immediately; after release no spurious output until new input.
